// File: rtl/seg7_scan_driver_pkg.sv
// seg7_scan_driver_pkg
//   Shared display vocabulary: glyph codes used by the upstream FSMs to build
//   code_in, and the active-low 7-segment patterns ({g,f,e,d,c,b,a}) they map to.
//   No ports; imported by seg7_decode and seg7_scan_driver.
package seg7_scan_driver_pkg;

  typedef logic [3:0] glyph_t;
  typedef logic [6:0] seg_t;

  // Non-numeric glyph codes (0..9 are the decimal digits themselves)
  localparam glyph_t GLY_UP    = 4'd10;
  localparam glyph_t GLY_DOWN  = 4'd11;
  localparam glyph_t GLY_F     = 4'd12;
  localparam glyph_t GLY_S     = 4'd13;
  localparam glyph_t GLY_BLANK = 4'd15;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam seg_t SEG_0     = 7'b100_0000;
  localparam seg_t SEG_1     = 7'b111_1001;
  localparam seg_t SEG_2     = 7'b010_0100;
  localparam seg_t SEG_3     = 7'b011_0000;
  localparam seg_t SEG_4     = 7'b001_1001;
  localparam seg_t SEG_5     = 7'b001_0010;
  localparam seg_t SEG_6     = 7'b000_0010;
  localparam seg_t SEG_7     = 7'b111_1000;
  localparam seg_t SEG_8     = 7'b000_0000;
  localparam seg_t SEG_9     = 7'b001_0000;
  localparam seg_t SEG_UP    = 7'b101_1100;
  localparam seg_t SEG_DOWN  = 7'b110_0011;
  localparam seg_t SEG_F     = 7'b000_1110;
  localparam seg_t SEG_S     = 7'b001_0010;
  localparam seg_t SEG_BLANK = 7'b111_1111;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
//   Purely combinational glyph decoder, shared by every display consumer.
//   Ports:
//     code  in  4  glyph code (0..9 digits, UP, DOWN, F, S, 14/15 blank)
//     seg   out 7  active-low segments {g,f,e,d,c,b,a}
module seg7_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:     seg = SEG_0;
      4'd1:     seg = SEG_1;
      4'd2:     seg = SEG_2;
      4'd3:     seg = SEG_3;
      4'd4:     seg = SEG_4;
      4'd5:     seg = SEG_5;
      4'd6:     seg = SEG_6;
      4'd7:     seg = SEG_7;
      4'd8:     seg = SEG_8;
      4'd9:     seg = SEG_9;
      GLY_UP:   seg = SEG_UP;
      GLY_DOWN: seg = SEG_DOWN;
      GLY_F:    seg = SEG_F;
      GLY_S:    seg = SEG_S;
      // 14 and GLY_BLANK both stay dark
      default:  seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexes four glyph codes onto a 4-digit common-anode display.
//   A prescaler advances the digit index every SCAN_DIV cycles; the codes are
//   latched into a shadow register once per frame so a frame never tears, and
//   the first BLANK_CYC cycles of every slot keep all anodes off.
//   Ports:
//     clk         in   1   system clock
//     rst         in   1   asynchronous, active-high reset
//     en          in   1   1 = scanning; 0 = dark, scan position frozen
//     code_in     in   16  glyph codes, [3:0] = rightmost digit (idx0)
//     DIGIT       out  4   anode enables, active-low, bit i = digit idx i
//     DISPLAY     out  7   segments {g,f,e,d,c,b,a}, active-low
//     frame_done  out  1   one-cycle pulse when a new frame is latched
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV  = 25000,
  parameter int BLANK_CYC = 2,
  parameter int CNT_W     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] code_in,
  output logic [3:0]  DIGIT,
  output logic [6:0]  DISPLAY,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       idx_reg;
  logic [15:0]      shadow_reg;
  logic [3:0]       digit_reg;
  logic [6:0]       display_reg;
  logic             frame_done_reg;

  glyph_t digit_code [4];
  glyph_t code_sel;
  seg_t   seg_sel;
  logic   in_gap;
  logic   lit;

  // Split the shadow word into per-digit glyph codes
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slice
      assign digit_code[gi] = shadow_reg[4*gi +: 4];
    end
  endgenerate

  // With no blank gap the comparison would be constant, so skip it entirely
  generate
    if (BLANK_CYC == 0) begin : g_no_gap
      assign in_gap = 1'b0;
    end else begin : g_gap
      assign in_gap = (cnt_reg < CNT_W'(BLANK_CYC));
    end
  endgenerate

  assign lit      = en && !in_gap;
  assign code_sel = digit_code[idx_reg];

  seg7_decode u_decode (
    .code (code_sel),
    .seg  (seg_sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg        <= '0;
      idx_reg        <= 2'd0;
      shadow_reg     <= 16'hFFFF;
      digit_reg      <= 4'b1111;
      display_reg    <= SEG_BLANK;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (en) begin
        if (cnt_reg == CNT_LAST) begin
          cnt_reg <= '0;
          idx_reg <= idx_reg + 2'd1;
          // Latch new codes only at the very end of the last slot
          if (idx_reg == 2'd3) begin
            shadow_reg     <= code_in;
            frame_done_reg <= 1'b1;
          end
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
      // Anode and segments come from the same (cnt, idx, shadow) snapshot, so an
      // anode is never enabled while the segments still show the previous digit.
      digit_reg   <= lit ? ~(4'b0001 << idx_reg) : 4'b1111;
      display_reg <= lit ? seg_sel : SEG_BLANK;
    end
  end

  assign DIGIT      = digit_reg;
  assign DISPLAY    = display_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Scoreboard bench for seg7_scan_driver (SCAN_DIV=4, BLANK_CYC=1).
//   The stimulus process pushes, for every clock it drives, the hand-computed
//   outputs expected after that edge; a negedge monitor pops and compares them
//   and also checks the one-anode and single-pulse invariants every cycle.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] code_in;
  logic [3:0]  DIGIT;
  logic [6:0]  DISPLAY;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic fd_prev = 1'b0;

  typedef struct {
    int         due;
    logic [3:0] dig;
    logic [6:0] disp;
    logic       fd;
    string      tag;
  } exp_t;

  exp_t sb_q[$];

  localparam logic [3:0] DIG_ON [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  localparam logic [6:0] S0  = 7'b100_0000;
  localparam logic [6:0] S1  = 7'b111_1001;
  localparam logic [6:0] S2  = 7'b010_0100;
  localparam logic [6:0] S3  = 7'b011_0000;
  localparam logic [6:0] S4  = 7'b001_1001;
  localparam logic [6:0] S5  = 7'b001_0010;
  localparam logic [6:0] S6  = 7'b000_0010;
  localparam logic [6:0] S7  = 7'b111_1000;
  localparam logic [6:0] S8  = 7'b000_0000;
  localparam logic [6:0] SUP = 7'b101_1100;
  localparam logic [6:0] SDN = 7'b110_0011;
  localparam logic [6:0] SF  = 7'b000_1110;
  localparam logic [6:0] SS  = 7'b001_0010;
  localparam logic [6:0] SB  = 7'b111_1111;

  seg7_scan_driver #(
    .SCAN_DIV  (4),
    .BLANK_CYC (1),
    .CNT_W     (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .code_in    (code_in),
    .DIGIT      (DIGIT),
    .DISPLAY    (DISPLAY),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(string tag, logic [3:0] ed, logic [6:0] es, logic ef);
    checks++;
    if (DIGIT !== ed || DISPLAY !== es || frame_done !== ef) begin
      errors++;
      $display("FAIL %s cyc=%0d: got DIGIT=%b DISPLAY=%b frame_done=%b, want DIGIT=%b DISPLAY=%b frame_done=%b",
               tag, cyc, DIGIT, DISPLAY, frame_done, ed, es, ef);
    end else begin
      $display("ok   %s cyc=%0d DIGIT=%b DISPLAY=%b frame_done=%b", tag, cyc, DIGIT, DISPLAY, frame_done);
    end
  endtask

  // Monitor: compare every due expectation, then the per-cycle invariants
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      if (e.due < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cyc=%0d missed (now cyc=%0d)", e.tag, e.due, cyc);
      end else begin
        check(e.tag, e.dig, e.disp, e.fd);
      end
    end
    checks++;
    if ($countones(~DIGIT) > 1) begin
      errors++;
      $display("FAIL one_anode cyc=%0d: got DIGIT=%b, want at most one low bit", cyc, DIGIT);
    end
    checks++;
    if (frame_done === 1'b1 && fd_prev === 1'b1) begin
      errors++;
      $display("FAIL fd_pulse cyc=%0d: got frame_done high two cycles, want single pulse", cyc);
    end
    fd_prev = frame_done;
  end

  // Drive one clock: inputs now, expected outputs after the coming edge
  task automatic step(logic e, logic [3:0] ed, logic [6:0] es, logic ef, string tag);
    en = e;
    sb_q.push_back('{cyc + 1, ed, es, ef, tag});
    @(posedge clk);
    #1;
  endtask

  // One full digit slot: a dark gap cycle, then three lit cycles
  task automatic slot(logic [1:0] i, logic [6:0] seg, logic fd_last, string tag);
    step(1'b1, 4'b1111, SB, 1'b0, $sformatf("%s_idx%0d_gap", tag, i));
    for (int c = 1; c < 4; c++)
      step(1'b1, DIG_ON[i], seg, (c == 3) && fd_last, $sformatf("%s_idx%0d_c%0d", tag, i, c));
  endtask

  task automatic frame(logic [6:0] s0, logic [6:0] s1, logic [6:0] s2, logic [6:0] s3, string tag);
    slot(2'd0, s0, 1'b0, tag);
    slot(2'd1, s1, 1'b0, tag);
    slot(2'd2, s2, 1'b0, tag);
    slot(2'd3, s3, 1'b1, tag);
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    code_in = 16'h1234;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 4'b1111, SB, 1'b0);
    rst = 1'b0;

    // 1: first frame blank, second frame shows 1234
    frame(SB, SB, SB, SB, "t1_blank");
    code_in = 16'hABCD;
    frame(S4, S3, S2, S1, "t1_1234");

    // 2: ABCD shown; code_in changes mid idx1 slot without tearing
    slot(2'd0, SS, 1'b0, "t2");
    step(1'b1, 4'b1111, SB, 1'b0, "t2_idx1_gap");
    step(1'b1, 4'b1101, SF, 1'b0, "t2_idx1_c1");
    code_in = 16'h0000;
    step(1'b1, 4'b1101, SF, 1'b0, "t2_idx1_c2");
    step(1'b1, 4'b1101, SF, 1'b0, "t2_idx1_c3");
    slot(2'd2, SDN, 1'b0, "t2");
    slot(2'd3, SUP, 1'b1, "t2");
    code_in = 16'hEFEF;
    frame(S0, S0, S0, S0, "t2_zeros");

    // 3: codes E/F blank while anodes still scan
    code_in = 16'h5678;
    frame(SB, SB, SB, SB, "t3_ef");

    // 4: en dropped for 10 cycles inside the idx2 slot
    slot(2'd0, S8, 1'b0, "t4");
    slot(2'd1, S7, 1'b0, "t4");
    step(1'b1, 4'b1111, SB, 1'b0, "t4_idx2_gap");
    step(1'b1, 4'b1011, S6, 1'b0, "t4_idx2_c1");
    for (int k = 0; k < 10; k++)
      step(1'b0, 4'b1111, SB, 1'b0, $sformatf("t4_en_off%0d", k));
    step(1'b1, 4'b1011, S6, 1'b0, "t4_idx2_c2");
    step(1'b1, 4'b1011, S6, 1'b0, "t4_idx2_c3");
    slot(2'd3, S5, 1'b1, "t4");

    // 5: async reset during idx3 slot with cnt=2
    slot(2'd0, S8, 1'b0, "t5");
    slot(2'd1, S7, 1'b0, "t5");
    slot(2'd2, S6, 1'b0, "t5");
    step(1'b1, 4'b1111, SB, 1'b0, "t5_idx3_gap");
    step(1'b1, 4'b0111, S5, 1'b0, "t5_idx3_c1");
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t5_async_rst", 4'b1111, SB, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("t5_rst_hold", 4'b1111, SB, 1'b0);
    rst = 1'b0;
    frame(SB, SB, SB, SB, "t5_blank");
    frame(S8, S7, S6, S5, "t5_refill");

    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(negedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
